// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: shared state enum and constants for the instruction memory responder
package imem_responder_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam int MEM_WORDS_DEF = 8192;
  localparam int LANES = 4;
endpackage

// File: rtl/imem_responder_byte_packer.sv
// imem_responder_byte_packer: packs little-endian bytes into 32-bit words (clk, reset, clear, accept, byte_in, last -> word_valid, word_data, is_last_flush)
module imem_responder_byte_packer
  import imem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  input  logic        last,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic        is_last_flush
);
  logic [1:0]  lane;
  logic [31:0] asm_q;
  // asm_q only ever holds lanes below the current one, so upper lanes are already zero-padded
  assign word_data     = asm_q | ({24'b0, byte_in} << {lane, 3'b000});
  assign word_valid    = accept & ((lane == 2'(LANES - 1)) | last);
  assign is_last_flush = accept & last;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane  <= '0;
      asm_q <= '0;
    end else if (accept) begin
      lane  <= word_valid ? '0 : lane + 2'd1;
      asm_q <= word_valid ? '0 : word_data;
    end
  end
endmodule

// File: rtl/imem_responder.sv
// imem_responder: instruction memory with 1-cycle fetch (fetch_req/addr -> fetch_valid/instr/fault, busy) and byte-stream program load (load_start/valid/byte/last -> load_ready/done/err)
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int          MEM_WORDS = MEM_WORDS_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic        fetch_fault,
  output logic        busy,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        load_ready,
  output logic        load_done,
  output logic        load_err
);
  localparam int PW = $clog2(MEM_WORDS) + 1;
  localparam int AW = PW - 1;
  state_t state, state_next;
  logic [PW-1:0] ptr;
  logic [31:0] mem [MEM_WORDS];
  logic accept, word_valid, is_last_flush, full, fetch_ok, fault;
  logic [31:0] word_data;
  assign busy       = state == LOAD;
  assign load_ready = busy;
  assign accept     = load_valid & busy & ~load_start & ~reset;
  // ptr saturates at MEM_WORDS, so its top bit alone flags a full memory
  assign full       = ptr[PW-1];
  assign fetch_ok   = fetch_req & ~busy;
  assign fault      = (|fetch_addr[1:0]) | ({2'b00, fetch_addr[31:2]} >= 32'(MEM_WORDS));
  imem_responder_byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear        (load_start),
    .accept       (accept),
    .byte_in      (load_byte),
    .last         (load_last),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .is_last_flush(is_last_flush)
  );
  always_comb begin
    state_next = load_start ? LOAD : is_last_flush ? RUN : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      load_err    <= 1'b0;
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_instr <= '0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_next;
      load_done   <= is_last_flush;
      fetch_valid <= fetch_ok;
      if (load_start) begin
        ptr      <= '0;
        load_err <= 1'b0;
      end else if (word_valid) begin
        if (full) load_err <= 1'b1;
        else ptr <= ptr + 1'b1;
      end
      if (fetch_ok) begin
        fetch_instr <= fault ? NOP_INSTR : mem[fetch_addr[AW+1:2]];
        fetch_fault <= fault;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (word_valid && !full) mem[ptr[AW-1:0]] <= word_data;
  end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: randomized and directed checks of two imem_responder instances against a byte-stream model
module tb_imem_responder;
  logic clk = 0, reset = 1, fetch_req = 0, load_start = 0, load_valid = 0, load_last = 0;
  logic [31:0] fetch_addr = 0;
  logic [7:0] load_byte = 0;
  logic [1:0] fv, ff, bsy, lrdy, ldone, lerr;
  logic [1:0][31:0] fi;
  int passed = 0, total = 0;
  bit armed = 0;
  int depth [2] = '{8192, 4};
  logic [31:0] mm [2][8192];
  logic [31:0] m_cur [2], m_fi [2];
  bit m_load [2], m_err [2], m_done [2], m_fv [2], m_ff [2];
  int m_n [2];
  always #5 clk = ~clk;
  imem_responder dut0 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fv[0]), .fetch_instr(fi[0]), .fetch_fault(ff[0]), .busy(bsy[0]),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
    .load_ready(lrdy[0]), .load_done(ldone[0]), .load_err(lerr[0])
  );
  imem_responder #(.MEM_WORDS(4)) dut4 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fv[1]), .fetch_instr(fi[1]), .fetch_fault(ff[1]), .busy(bsy[1]),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
    .load_ready(lrdy[1]), .load_done(ldone[1]), .load_err(lerr[1])
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    else passed++;
  endtask
  initial for (int k = 0; k < 2; k++) for (int i = 0; i < 8192; i++) mm[k][i] = '0;
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_load[k] = 0; m_err[k] = 0; m_done[k] = 0; m_fv[k] = 0; m_n[k] = 0; m_cur[k] = 0;
        armed = 1;
      end else begin
        m_done[k] = 0;
        m_fv[k] = fetch_req && !m_load[k];
        if (m_fv[k]) begin
          m_ff[k] = fetch_addr[1:0] != 0 || (fetch_addr >> 2) >= depth[k];
          m_fi[k] = m_ff[k] ? 32'h13 : mm[k][fetch_addr >> 2];
        end
        if (load_start) begin
          m_load[k] = 1; m_n[k] = 0; m_err[k] = 0; m_cur[k] = 0;
        end else if (m_load[k] && load_valid) begin
          m_cur[k][8*(m_n[k]%4) +: 8] = load_byte;
          m_n[k]++;
          if (m_n[k] % 4 == 0 || load_last) begin
            if ((m_n[k] - 1) / 4 < depth[k]) mm[k][(m_n[k] - 1) / 4] = m_cur[k];
            else m_err[k] = 1;
            m_cur[k] = 0;
          end
          if (load_last) begin
            m_load[k] = 0; m_done[k] = 1;
          end
        end
      end
    end
  end
  always @(negedge clk) begin
    if (armed) for (int k = 0; k < 2; k++) begin
      chk($sformatf("fetch_valid[%0d]", k), 32'(fv[k]), 32'(m_fv[k]));
      if (m_fv[k]) begin
        chk($sformatf("fetch_instr[%0d]", k), fi[k], m_fi[k]);
        chk($sformatf("fetch_fault[%0d]", k), 32'(ff[k]), 32'(m_ff[k]));
      end
      chk($sformatf("busy[%0d]", k), 32'(bsy[k]), 32'(m_load[k]));
      chk($sformatf("load_ready[%0d]", k), 32'(lrdy[k]), 32'(m_load[k]));
      chk($sformatf("load_done[%0d]", k), 32'(ldone[k]), 32'(m_done[k]));
      chk($sformatf("load_err[%0d]", k), 32'(lerr[k]), 32'(m_err[k]));
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic start();
    load_start = 1; tick(); load_start = 0;
  endtask
  task automatic lb(input logic [7:0] b, input bit l);
    load_valid = 1; load_byte = b; load_last = l; tick(); load_valid = 0; load_last = 0;
  endtask
  task automatic fetch_lit(input int k, input logic [31:0] a, input logic [31:0] ei, input bit ef);
    fetch_req = 1; fetch_addr = a; tick(); fetch_req = 0;
    chk("lit_valid", 32'(fv[k]), 32'd1);
    chk("lit_instr", fi[k], ei);
    chk("lit_fault", 32'(ff[k]), 32'(ef));
  endtask
  initial begin
    tick(); tick();
    reset = 0;
    chk("reset_busy", 32'(bsy[0]), 32'd0);
    chk("reset_err", 32'(lerr[0]), 32'd0);
    fetch_lit(0, 32'h0, 32'h0, 0);
    start();
    lb(8'h93, 0); lb(8'h00, 0); lb(8'h10, 0); lb(8'h00, 1);
    chk("done_pulse", 32'(ldone[0]), 32'd1);
    chk("model_mem0", mm[0][0], 32'h0010_0093);
    fetch_lit(0, 32'h0, 32'h0010_0093, 0);
    chk("done_once", 32'(ldone[0]), 32'd0);
    start();
    for (int i = 1; i <= 6; i++) lb(8'(i), i == 6);
    fetch_lit(0, 32'h0, 32'h0403_0201, 0);
    fetch_lit(0, 32'h4, 32'h0000_0605, 0);
    fetch_lit(0, 32'h2, 32'h0000_0013, 1);
    fetch_lit(0, 32'h8000, 32'h0000_0013, 1);
    fetch_lit(0, 32'h7FFC, 32'h0, 0);
    start();
    fetch_req = 1;
    lb(8'h11, 0); lb(8'h22, 0);
    fetch_req = 0;
    chk("load_fetch_blocked", 32'(fv[0]), 32'd0);
    chk("load_busy", 32'(bsy[0]), 32'd1);
    start();
    lb(8'hAA, 0); lb(8'hBB, 0); lb(8'hCC, 0); lb(8'hDD, 1);
    fetch_lit(0, 32'h0, 32'hDDCC_BBAA, 0);
    start();
    for (int i = 1; i <= 20; i++) lb(8'(i), i == 20);
    chk("ovf_done", 32'(ldone[1]), 32'd1);
    chk("ovf_err", 32'(lerr[1]), 32'd1);
    chk("noovf_err", 32'(lerr[0]), 32'd0);
    fetch_lit(1, 32'hC, 32'h100F_0E0D, 0);
    fetch_lit(1, 32'h10, 32'h0000_0013, 1);
    start();
    lb(8'hEE, 0); lb(8'hEE, 0); lb(8'hEE, 0);
    reset = 1; tick(); reset = 0;
    chk("rst_mid_busy", 32'(bsy[1]), 32'd0);
    chk("rst_mid_err", 32'(lerr[1]), 32'd0);
    fetch_lit(1, 32'h0, 32'h0403_0201, 0);
    fetch_lit(0, 32'h10, 32'h1413_1211, 0);
    for (int c = 0; c < 3000; c++) begin
      reset = $urandom_range(0, 499) == 0;
      load_start = $urandom_range(0, 39) == 0;
      load_valid = $urandom_range(0, 1) == 1;
      load_last = $urandom_range(0, 11) == 0;
      load_byte = 8'($urandom);
      fetch_req = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0: fetch_addr = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
        1: fetch_addr = {25'd0, 5'($urandom), 2'($urandom_range(1, 3))};
        2: fetch_addr = $urandom;
        default: fetch_addr = {17'd0, 13'($urandom_range(8185, 8191)), 2'b00} + ($urandom_range(0, 1) << 15);
      endcase
      tick();
    end
    reset = 0; load_start = 0; load_valid = 0; load_last = 0; fetch_req = 0;
    tick(); tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
